// File: rtl/limb_pkg.sv
// Shared constants, FSM encodings and the completion-data helper for the LIMB Wishbone master.
package limb_pkg;

  localparam int LIMB_ADR_W = 36;
  localparam int LIMB_DAT_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  // Failed completions report all-ones, writes report zero, reads return the bus data.
  function automatic logic [LIMB_DAT_W-1:0] completion_dat(
    input logic                  failed,
    input logic                  we,
    input logic [LIMB_DAT_W-1:0] rd
  );
    if (failed) return '1;
    if (we) return '0;
    return rd;
  endfunction

endpackage

// File: rtl/limb_wb_timer.sv
// Bus-cycle watchdog for limb_wb_master; only instantiated when LIMB_WB_TIMEOUT_EN is defined.
module limb_wb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 16'd1;
    end
  end

  // count holds the number of completed ACTIVE cycles, so this fires in the last allowed one
  assign expired = run && (count == LAST_COUNT);

endmodule

// File: rtl/limb_wb_master.sv
// Single-outstanding Wishbone classic master for LIMB commands.
// Optional bus timeout enabled by defining LIMB_WB_TIMEOUT_EN.
module limb_wb_master
  import limb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [LIMB_ADR_W-1:0] cmd_adr,
  input  logic [LIMB_DAT_W-1:0] cmd_dat,
  output logic                  rsp_valid,
  output logic [LIMB_DAT_W-1:0] rsp_dat,
  output logic                  rsp_err,
  output logic [LIMB_ADR_W-1:0] wb_adr_o,
  output logic [LIMB_DAT_W-1:0] wb_dat_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic [LIMB_DAT_W-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic [1:0]            fsm_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both 1;
  // cmd_ready is registered and is only 1 in IDLE. rsp_valid is a one-cycle pulse with no backpressure.

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("limb_wb_master: TIMEOUT_CYCLES must be within 1..65535");
  end

  logic [1:0] state;
  logic       accept;
  logic       timed_out;
  logic       finish;
  logic       failed;

  assign accept    = cmd_valid && cmd_ready;
  assign fsm_state = state;

`ifdef LIMB_WB_TIMEOUT_EN
  limb_wb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .run    (state == ST_ACTIVE),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // A slave response in the final allowed cycle wins over the timeout; err always wins over ack.
  assign finish = (state == ST_ACTIVE) && (wb_ack_i || wb_err_i || timed_out);
  assign failed = wb_err_i || (!wb_ack_i && timed_out);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            wb_adr_o  <= cmd_adr;
            wb_dat_o  <= cmd_dat;
            wb_we_o   <= cmd_we;
            wb_sel_o  <= WB_SEL_ALL;
            wb_stb_o  <= 1'b1;
            wb_cyc_o  <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= ST_ACTIVE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (finish) begin
            wb_sel_o  <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= failed;
            rsp_dat   <= completion_dat(failed, wb_we_o, wb_dat_i);
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
          wb_sel_o  <= '0;
          wb_stb_o  <= 1'b0;
          wb_cyc_o  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_limb_wb_master.sv
// Self-checking bench for limb_wb_master: directed corner cases plus randomized traffic
// against a transaction-level model of expected responses and bus cycle lengths.
module tb_limb_wb_master;
  import limb_pkg::*;

`ifdef LIMB_WB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_BOTH   = 2;
  localparam int K_SILENT = 3;
  localparam int K_ABORT  = 4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [35:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [35:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [1:0]  fsm_state;

  limb_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  int cyc_no = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_no++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        we;
    logic [35:0] adr;
    logic [31:0] dat;
    int          wait_c;
    int          kind;
    logic [31:0] rdata;
    int          exp_len;
  } txn_t;

  txn_t        slave_q[$];
  logic [32:0] exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  function automatic txn_t mk_txn(input logic we, input logic [35:0] adr, input logic [31:0] dat,
                                  input int wait_c, input int kind, input logic [31:0] rdata);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat; t.wait_c = wait_c; t.kind = kind; t.rdata = rdata;
    if (kind <= K_BOTH) t.exp_len = wait_c + 1;
    else if (kind == K_ABORT) t.exp_len = 2;
    else t.exp_len = TO_EN ? TO : -1;
    return t;
  endfunction

  function automatic logic [32:0] expect_rsp(input txn_t t);
    if (t.kind == K_ACK) return {1'b0, (t.we ? 32'h0 : t.rdata)};
    return {1'b1, 32'hFFFF_FFFF};
  endfunction

  // ---------------- Wishbone slave model ----------------
  txn_t cur;
  bit   sl_busy = 1'b0;
  int   sl_len = 0;
  int   sl_wait = 0;
  bit   poke = 1'b0;

  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = $urandom;
    if (wb_cyc_o === 1'b1) begin
      if (!sl_busy) begin
        if (slave_q.size() == 0) check_eq("unexpected_cyc", 64'(1), 64'(0));
        else cur = slave_q.pop_front();
        sl_busy = 1'b1;
        sl_len = 0;
        sl_wait = cur.wait_c;
      end
      sl_len++;
      check_eq("bus_stb", 64'(wb_stb_o), 64'(1));
      check_eq("bus_sel", 64'(wb_sel_o), 64'(4'hF));
      check_eq("bus_adr", 64'(wb_adr_o), 64'(cur.adr));
      check_eq("bus_dat", 64'(wb_dat_o), 64'(cur.dat));
      check_eq("bus_we", 64'(wb_we_o), 64'(cur.we));
      if (cur.kind <= K_BOTH) begin
        if (sl_wait == 0) begin
          wb_dat_i = cur.rdata;
          wb_ack_i = (cur.kind != K_ERR);
          wb_err_i = (cur.kind != K_ACK);
        end else begin
          sl_wait--;
        end
      end
    end else begin
      if (sl_busy) begin
        if (cur.exp_len >= 0) check_eq("cyc_len", 64'(sl_len), 64'(cur.exp_len));
        check_eq("idle_sel_stb", 64'({wb_sel_o, wb_stb_o}), 64'(0));
        sl_busy = 1'b0;
      end
      if (poke) begin
        wb_ack_i = 1'b1;
        wb_err_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- response monitor ----------------
  logic [32:0] last_rsp;
  bit          prev_valid = 1'b0;

  always @(negedge clk) begin
    if (prev_valid) begin
      check_eq("rsp_pulse_width", 64'(rsp_valid), 64'(0));
      check_eq("rsp_hold", 64'({rsp_err, rsp_dat}), 64'(last_rsp));
    end
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("rsp_unexpected", 64'(1), 64'(0));
      else check_eq("rsp", 64'({rsp_err, rsp_dat}), 64'(exp_q.pop_front()));
    end
    prev_valid = (rsp_valid === 1'b1);
    last_rsp = {rsp_err, rsp_dat};
  end

  // ---------------- driver tasks ----------------
  int accept_cyc;

  task automatic send_cmd(input txn_t t, input bit keep);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check_eq("ready_wait", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    slave_q.push_back(t);
    if (t.kind != K_ABORT && t.exp_len >= 0) exp_q.push_back(expect_rsp(t));
    cmd_valid = 1'b1;
    cmd_we = t.we;
    cmd_adr = t.adr;
    cmd_dat = t.dat;
    accept_cyc = cyc_no;
    @(negedge clk);
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_dat = $urandom;
    end
    check_eq("cyc_after_accept", 64'({wb_cyc_o, wb_stb_o, cmd_ready}), 64'(3'b110));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || sl_busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_timeout", 64'(guard >= 200), 64'(0));
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc[3];
    int kr;
    txn_t t;

    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_adr = '0;
    cmd_dat = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_bus", 64'({wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o}), 64'(0));
    check_eq("reset_rsp", 64'({rsp_valid, rsp_err, rsp_dat}), 64'(0));
    check_eq("reset_ready", 64'(cmd_ready), 64'(0));
    check_eq("reset_state", 64'(fsm_state), 64'(ST_IDLE));
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", 64'(cmd_ready), 64'(1));

    // read with two wait states
    send_cmd(mk_txn(1'b0, 36'h0_1234_5678, 32'h1111_2222, 2, K_ACK, 32'hDEAD_BEEF), 1'b0);
    drain();
    // write with immediate ack
    send_cmd(mk_txn(1'b1, 36'hF_0000_0004, 32'hA5A5_A5A5, 0, K_ACK, 32'h7777_7777), 1'b0);
    drain();
    // ack and err together, then err alone on a write
    send_cmd(mk_txn(1'b0, 36'h3_0000_0010, 32'h0, 1, K_BOTH, 32'h1234_5678), 1'b0);
    drain();
    send_cmd(mk_txn(1'b1, 36'h3_0000_0014, 32'hCAFE_F00D, 0, K_ERR, 32'h0), 1'b0);
    drain();
    // ack in the last cycle before a timeout would fire
    send_cmd(mk_txn(1'b0, 36'h5_5555_5554, 32'h0, 3, K_ACK, 32'h0BAD_F00D), 1'b0);
    drain();

    // three back-to-back commands with cmd_valid held high
    for (int i = 0; i < 3; i++) begin
      send_cmd(mk_txn(1'b0, 36'(36'h100 + 4 * i), 32'h0, 0, K_ACK, 32'(32'hA000_0000 + i)), i < 2);
      acc[i] = accept_cyc;
    end
    drain();
    check_eq("b2b_spacing_0", 64'(acc[1] - acc[0]), 64'(3));
    check_eq("b2b_spacing_1", 64'(acc[2] - acc[1]), 64'(3));

    // silent slave
    send_cmd(mk_txn(1'b0, 36'h9_8765_4320, 32'h0, 0, K_SILENT, 32'h0), 1'b0);
    if (TO_EN) begin
      drain();
    end else begin
      repeat (1000) @(negedge clk);
      check_eq("no_timeout_cyc", 64'(wb_cyc_o), 64'(1));
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("ready_after_stuck", 64'(cmd_ready), 64'(1));
    end

    // reset in the second ACTIVE cycle
    send_cmd(mk_txn(1'b1, 36'h2_2222_2220, 32'h4444_4444, 0, K_ABORT, 32'h0), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_bus", 64'({wb_cyc_o, wb_stb_o, wb_sel_o}), 64'(0));
    check_eq("abort_rsp", 64'({rsp_valid, rsp_err, rsp_dat, cmd_ready}), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_abort", 64'(cmd_ready), 64'(1));
    repeat (2) @(negedge clk);

    // randomized traffic with occasional stray acks while idle
    for (int n = 0; n < 40; n++) begin
      kr = $urandom_range(0, 9);
      t = mk_txn(1'($urandom_range(0, 1)), {4'($urandom_range(0, 15)), 32'($urandom)}, 32'($urandom),
                 $urandom_range(0, 3), (kr < 6) ? K_ACK : ((kr < 8) ? K_ERR : K_BOTH), 32'($urandom));
      send_cmd(t, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        drain();
        poke = 1'b1;
        repeat (2) @(negedge clk);
        poke = 1'b0;
        @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain();
    check_eq("scoreboard_empty", 64'(exp_q.size() + slave_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/limb_wb_master.md
LIMB_WB_MASTER -- requirements
Module: limb_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, Wishbone cycles waited for ack/err before abort (legal 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command presented by the LIMB decode stage.
REQ-005 SHALL have port cmd_ready  output  1  block can accept a command this cycle.
REQ-006 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr  input  36  byte address of the transaction.
REQ-008 SHALL have port cmd_dat  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_dat  output  32  read data, held until next completion.
REQ-011 SHALL have port rsp_err  output  1  completion failed (bus error or timeout), held until next completion.
REQ-012 SHALL have ports wb_adr_o 36, wb_dat_o 32, wb_we_o 1, wb_sel_o 4, wb_stb_o 1, wb_cyc_o 1 as outputs, and wb_dat_i 32, wb_ack_i 1, wb_err_i 1 as inputs, forming a Wishbone classic master.

Function
REQ-013 SHALL implement FSM states IDLE, ACTIVE, RESP; cmd_ready = 1 only in IDLE.
REQ-014 SHALL, in IDLE with cmd_valid = 1, register cmd_adr/cmd_dat/cmd_we onto wb_adr_o/wb_dat_o/wb_we_o and enter ACTIVE; a command accepted in cycle N gives wb_cyc_o = wb_stb_o = 1 in cycle N+1.
REQ-015 SHALL hold wb_cyc_o, wb_stb_o, wb_sel_o = 4'b1111 and all wb_*_o values stable throughout ACTIVE.
REQ-016 SHALL, on wb_ack_i = 1 in ACTIVE at cycle M, capture wb_dat_i into rsp_dat for reads (rsp_dat = 0 for writes), clear rsp_err, deassert cyc/stb at M+1, enter RESP.
REQ-017 SHALL treat wb_err_i = 1 in ACTIVE like ack, but set rsp_err = 1 and rsp_dat = 32'hFFFFFFFF; simultaneous ack and err SHALL be treated as err.
REQ-018 SHALL, in RESP, assert rsp_valid for exactly one cycle (M+1), then return to IDLE; minimum accept-to-accept spacing is 3 cycles.
REQ-019 SHALL ignore wb_ack_i/wb_err_i outside ACTIVE.
REQ-020 SHALL keep wb_sel_o = 0 and wb_cyc_o = wb_stb_o = 0 outside ACTIVE.

Reset
REQ-021 SHALL, while reset = 0 at a clock edge, force state IDLE, all wb_*_o = 0, rsp_valid = 0, rsp_err = 0, rsp_dat = 0, cmd_ready = 0, timeout counter = 0.
REQ-022 SHALL, on reset mid-ACTIVE, drop wb_cyc_o/wb_stb_o next edge and produce no rsp_valid for the aborted command.
REQ-023 SHALL assert cmd_ready = 1 the first cycle after reset returns to 1.

Configuration
REQ-024 SHALL, with LIMB_WB_TIMEOUT_EN defined, count ACTIVE cycles in a 16-bit counter cleared on entry to ACTIVE and, when count reaches TIMEOUT_CYCLES without ack/err, deassert cyc/stb, set rsp_err = 1, rsp_dat = 32'hFFFFFFFF, and enter RESP.
REQ-025 SHALL, with LIMB_WB_TIMEOUT_EN undefined, contain no counter and wait in ACTIVE indefinitely; TIMEOUT_CYCLES is then unused.

Structure
REQ-026 SHALL take FSM state encodings and the constants LIMB_ADR_W = 36, LIMB_DAT_W = 32 from shared package limb_pkg.
REQ-027 SHALL place the timeout counter in sub-module limb_wb_timer (inputs clk, reset, clear, run; output expired), instantiated only under LIMB_WB_TIMEOUT_EN.

Verification
REQ-028 Read: cmd adr 36'h0_1234_5678, slave acks after 2 cycles with 32'hDEADBEEF -> rsp_valid pulse, rsp_dat = 32'hDEADBEEF, rsp_err = 0, cyc high exactly 3 cycles.
REQ-029 Write: cmd_we = 1, adr 36'hF_0000_0004, dat 32'hA5A5A5A5, immediate ack -> wb_dat_o/wb_adr_o match during cyc, wb_sel_o = 4'hF, rsp_dat = 0, rsp_err = 0.
REQ-030 Ack and err both asserted the same cycle -> rsp_err = 1, rsp_dat = 32'hFFFFFFFF.
REQ-031 TIMEOUT_CYCLES = 4, LIMB_WB_TIMEOUT_EN defined, slave silent -> cyc drops after 4 ACTIVE cycles, rsp_err = 1; macro undefined -> cyc still high after 1000 cycles.
REQ-032 cmd_valid held high for 3 back-to-back commands with single-cycle acks -> accepts spaced exactly 3 cycles, 3 rsp_valid pulses in order.
REQ-033 reset = 0 asserted in the second ACTIVE cycle -> cyc = 0 next edge, no rsp_valid, cmd_ready = 1 one cycle after reset returns to 1.
